// File: rtl/nn_acc_pkg.sv
// nn_acc_pkg: sequencer state encoding and default Conv1D layer dimensions
package nn_acc_pkg;
  typedef enum logic [2:0] {IDLE, CONV, DRAIN, LSTM_START, LSTM_WAIT, DONE} seq_state_t;
  localparam int N_OC = 128;
  localparam int K = 3;
  localparam int N_IN = 40;
  localparam int BEATS_PER_FRAME = N_OC * K * N_IN;
endpackage

// File: rtl/nn_conv_addr_gen.sv
// nn_conv_addr_gen: ic/tap/oc nested counters with incremental w_addr; in clear/advance, out w_addr/tap/ic/oc, first/last markers, wrap on final beat
module nn_conv_addr_gen #(
  parameter int N_OC = nn_acc_pkg::N_OC,
  parameter int K = nn_acc_pkg::K,
  parameter int N_IN = nn_acc_pkg::N_IN,
  parameter int AW = $clog2(N_OC * K * N_IN),
  parameter int OW = $clog2(N_OC),
  parameter int TW = $clog2(K),
  parameter int IW = $clog2(N_IN)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] w_addr,
  output logic [TW-1:0] tap,
  output logic [IW-1:0] ic,
  output logic [OW-1:0] oc,
  output logic          first,
  output logic          last,
  output logic          wrap
);
  logic ic_end, tap_end, oc_end;
  assign ic_end = ic == IW'(N_IN - 1);
  assign tap_end = tap == TW'(K - 1);
  assign oc_end = oc == OW'(N_OC - 1);
  assign first = tap == '0 && ic == '0;
  assign last = tap_end && ic_end;
  assign wrap = last && oc_end;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      w_addr <= '0;
      tap <= '0;
      ic <= '0;
      oc <= '0;
    end else if (clear) begin
      w_addr <= '0;
      tap <= '0;
      ic <= '0;
      oc <= '0;
    end else if (advance) begin
      ic <= ic_end ? '0 : ic + IW'(1);
      tap <= !ic_end ? tap : tap_end ? '0 : tap + TW'(1);
      oc <= !last ? oc : oc_end ? '0 : oc + OW'(1);
      w_addr <= wrap ? '0 : w_addr + AW'(1);
    end
endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: frame FSM; frame_valid/ready in, MAC requests (mac_*, w_addr, f_tap, f_ic, oc_idx), LSTM start/done handshake, busy/frame_done/frame_cnt/err status
module nn_layer_sequencer #(
  parameter int N_OC = nn_acc_pkg::N_OC,
  parameter int K = nn_acc_pkg::K,
  parameter int N_IN = nn_acc_pkg::N_IN,
  parameter int MAC_LAT = 4,
  parameter int AW = $clog2(N_OC * K * N_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  output logic                    mac_valid,
  input  logic                    mac_ready,
  output logic                    mac_first,
  output logic                    mac_last,
  output logic [AW-1:0]           w_addr,
  output logic [$clog2(K)-1:0]    f_tap,
  output logic [$clog2(N_IN)-1:0] f_ic,
  output logic [$clog2(N_OC)-1:0] oc_idx,
  output logic                    lstm_start,
  input  logic                    lstm_done,
  output logic                    busy,
  output logic                    frame_done,
  output logic [15:0]             frame_cnt,
  output logic                    err
);
  import nn_acc_pkg::*;
  localparam int DW = MAC_LAT > 1 ? $clog2(MAC_LAT) : 1;
  seq_state_t state;
  logic [DW-1:0] drain_cnt;
  logic first, last, wrap, beat, start;
  assign beat = mac_valid && mac_ready;
  assign start = state == IDLE && frame_valid;
  assign mac_first = mac_valid && first;
  assign mac_last = mac_valid && last;
  nn_conv_addr_gen #(
    .N_OC(N_OC),
    .K(K),
    .N_IN(N_IN),
    .AW(AW)
  ) u_addr (
    .clk(clk),
    .reset_n(reset_n),
    .clear(start),
    .advance(beat),
    .w_addr(w_addr),
    .tap(f_tap),
    .ic(f_ic),
    .oc(oc_idx),
    .first(first),
    .last(last),
    .wrap(wrap)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      drain_cnt <= '0;
      frame_ready <= 1'b1;
      mac_valid <= 1'b0;
      lstm_start <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      lstm_start <= 1'b0;
      frame_done <= 1'b0;
      if (lstm_done && state != LSTM_WAIT) err <= 1'b1;
      case (state)
        IDLE: if (frame_valid) begin
          state <= CONV;
          frame_ready <= 1'b0;
          mac_valid <= 1'b1;
          busy <= 1'b1;
        end
        CONV: if (beat && wrap) begin
          state <= DRAIN;
          mac_valid <= 1'b0;
          drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DW'(MAC_LAT - 1)) begin
            state <= LSTM_START;
            lstm_start <= 1'b1;
          end
        end
        LSTM_START: state <= LSTM_WAIT;
        LSTM_WAIT: if (lstm_done) begin
          state <= DONE;
          frame_done <= 1'b1;
          frame_cnt <= frame_cnt + 16'd1;
        end
        DONE: begin
          state <= IDLE;
          frame_ready <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: scoreboard bench for the frame sequencer with small layer dimensions
module tb_nn_layer_sequencer;
  localparam int TN_OC = 2;
  localparam int TK = 3;
  localparam int TN_IN = 4;
  localparam int TLAT = 2;
  logic clk, reset_n, frame_valid, frame_ready, mac_valid, mac_ready, mac_first, mac_last;
  logic [4:0] w_addr;
  logic [1:0] f_tap, f_ic;
  logic [0:0] oc_idx;
  logic lstm_start, lstm_done, busy, frame_done, err, bp;
  logic [15:0] frame_cnt, exp_cnt;
  logic [11:0] exp_q[$];
  logic [15:0] cnt_q[$];
  int checks, errors, beats, cyc, last_beat_cyc, done_cyc, ph;
  nn_layer_sequencer #(
    .N_OC(TN_OC),
    .K(TK),
    .N_IN(TN_IN),
    .MAC_LAT(TLAT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .mac_valid(mac_valid),
    .mac_ready(mac_ready),
    .mac_first(mac_first),
    .mac_last(mac_last),
    .w_addr(w_addr),
    .f_tap(f_tap),
    .f_ic(f_ic),
    .oc_idx(oc_idx),
    .lstm_start(lstm_start),
    .lstm_done(lstm_done),
    .busy(busy),
    .frame_done(frame_done),
    .frame_cnt(frame_cnt),
    .err(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s got event want none at cycle %0d", name, cyc);
  endtask
  task automatic push_frame();
    for (int o = 0; o < TN_OC; o++)
      for (int t = 0; t < TK; t++)
        for (int i = 0; i < TN_IN; i++) begin
          logic [4:0] a;
          a = 5'(o * TK * TN_IN + t * TN_IN + i);
          exp_q.push_back({a, 2'(t), 2'(i), 1'(o), t == 0 && i == 0, t == TK - 1 && i == TN_IN - 1});
        end
    exp_cnt = exp_cnt + 16'd1;
    cnt_q.push_back(exp_cnt);
  endtask
  task automatic pulse_frame();
    @(posedge clk);
    #1 frame_valid = 1'b1;
    @(posedge clk);
    #1 frame_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 50);
    if (!frame_done) fail("frame_done_timeout");
  endtask
  task automatic finish_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lstm_start && n < 500);
    if (!lstm_start) fail("lstm_start_timeout");
    repeat (5) @(posedge clk);
    #1 lstm_done = 1'b1;
    @(posedge clk);
    #1 lstm_done = 1'b0;
    wait_done();
  endtask
  task automatic wait_beats(input int b);
    int n;
    n = 0;
    while (beats < b && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (beats < b) fail("beat_timeout");
  endtask
  initial begin
    mac_ready = 1'b1;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph == 2) ? 0 : ph + 1;
      mac_ready = !bp || ph == 0;
    end
  end
  always @(negedge clk)
    if (reset_n) begin
      if (mac_valid) begin
        if (exp_q.size() == 0) fail("beat_unexpected");
        else begin
          chk("beat", {w_addr, f_tap, f_ic, oc_idx, mac_first, mac_last}, exp_q[0]);
          if (mac_ready) begin
            void'(exp_q.pop_front());
            beats++;
            last_beat_cyc = cyc;
          end
        end
      end
      if (lstm_start) chk("lstm_start_lat", cyc - last_beat_cyc, TLAT + 1);
      if (lstm_done) done_cyc = cyc;
      if (frame_done) begin
        if (cnt_q.size() == 0) fail("frame_done_unexpected");
        else chk("frame_cnt", frame_cnt, cnt_q.pop_front());
        chk("frame_done_lat", cyc - done_cyc, 1);
      end
      if (busy) chk("ready_while_busy", frame_ready, 0);
    end
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  initial begin
    checks = 0;
    errors = 0;
    beats = 0;
    exp_cnt = 0;
    last_beat_cyc = 0;
    done_cyc = 0;
    bp = 1'b0;
    reset_n = 1'b0;
    frame_valid = 1'b0;
    lstm_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {frame_ready, mac_valid, mac_first, mac_last, lstm_start, frame_done, busy, err}, 8'b1000_0000);
    chk("rst_addr", {w_addr, f_tap, f_ic, oc_idx}, 0);
    chk("rst_cnt", frame_cnt, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    beats = 0;
    push_frame();
    pulse_frame();
    finish_frame();
    chk("happy_beats", beats, 24);
    chk("happy_cnt", frame_cnt, 1);
    chk("happy_err", err, 0);
    bp = 1'b1;
    beats = 0;
    push_frame();
    pulse_frame();
    finish_frame();
    bp = 1'b0;
    chk("bp_beats", beats, 24);
    chk("bp_cnt", frame_cnt, 2);
    beats = 0;
    push_frame();
    push_frame();
    @(posedge clk);
    #1 frame_valid = 1'b1;
    finish_frame();
    @(negedge clk);
    chk("b2b_ready", {frame_ready, busy}, 2'b10);
    @(negedge clk);
    chk("b2b_restart", {mac_valid, busy, frame_ready}, 3'b110);
    finish_frame();
    @(posedge clk);
    #1 frame_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_no_third", busy, 0);
    chk("b2b_beats", beats, 48);
    chk("b2b_cnt", frame_cnt, exp_cnt);
    @(posedge clk);
    #1 force dut.frame_cnt = 16'hFFFF;
    @(posedge clk);
    #1 release dut.frame_cnt;
    exp_cnt = 16'hFFFF;
    push_frame();
    pulse_frame();
    finish_frame();
    chk("wrap_cnt", frame_cnt, 16'h0000);
    beats = 0;
    push_frame();
    pulse_frame();
    wait_beats(10);
    #2 reset_n = 1'b0;
    exp_q.delete();
    cnt_q.delete();
    exp_cnt = 0;
    #1;
    chk("midrst_ctl", {frame_ready, mac_valid, mac_first, mac_last, lstm_start, frame_done, busy, err}, 8'b1000_0000);
    chk("midrst_addr", {w_addr, f_tap, f_ic, oc_idx}, 0);
    chk("midrst_cnt", frame_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_idle", {busy, frame_ready}, 2'b01);
    beats = 0;
    push_frame();
    pulse_frame();
    finish_frame();
    chk("midrst_beats", beats, 24);
    chk("midrst_next_cnt", frame_cnt, 1);
    beats = 0;
    push_frame();
    pulse_frame();
    wait_beats(5);
    @(posedge clk);
    #1 lstm_done = 1'b1;
    @(posedge clk);
    #1 lstm_done = 1'b0;
    @(negedge clk);
    chk("stray_conv_err", {err, busy, mac_valid}, 3'b111);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(mac_valid && mac_ready && mac_last && oc_idx == 1'b1) && n < 200);
      if (n >= 200) fail("last_beat_timeout");
    end
    repeat (3) @(posedge clk);
    #1 lstm_done = 1'b1;
    @(negedge clk);
    chk("stray_coincide", lstm_start, 1);
    @(posedge clk);
    #1 lstm_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_still_wait", {busy, frame_done, err}, 3'b101);
    @(posedge clk);
    #1 lstm_done = 1'b1;
    @(posedge clk);
    #1 lstm_done = 1'b0;
    wait_done();
    chk("stray_beats", beats, 24);
    chk("stray_cnt", frame_cnt, 2);
    repeat (2) @(negedge clk);
    chk("stray_err_sticky", {err, busy}, 2'b10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Control FSM that sequences one inference frame through the accelerator: Conv1D MAC sweep over all output channels, kernel taps and input features, then a handshake-driven LSTM step.
- Sits between the MFCC frame source and the Conv1D MAC array / LSTM engine.
- Generates weight and feature addresses plus first/last accumulate markers, honours MAC backpressure, and reports frame completion and a protocol error.

Parameters:
N_OC, 128, Conv1D output channels
K, 3, kernel taps
N_IN, 40, MFCC features per tap
MAC_LAT, 4, MAC pipeline depth in cycles; drain wait before LSTM start (>=1)
AW, $clog2(N_OC*K*N_IN), weight address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
frame_valid  in  1  new MFCC frame available
frame_ready  out  1  sequencer can accept a frame
mac_valid  out  1  MAC operand request valid
mac_ready  in  1  MAC accepts request
mac_first  out  1  first beat of an output channel (clear accumulator)
mac_last  out  1  last beat of an output channel (write result)
w_addr  out  AW  weight address = oc*K*N_IN + tap*N_IN + ic
f_tap  out  $clog2(K)  feature tap index
f_ic  out  $clog2(N_IN)  feature index
oc_idx  out  $clog2(N_OC)  current output channel
lstm_start  out  1  one-cycle LSTM start pulse
lstm_done  in  1  LSTM step complete (single-cycle pulse)
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle frame completion pulse
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
err  out  1  sticky protocol error

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all counters 0; frame_ready=1; mac_valid, mac_first, mac_last, lstm_start, frame_done, busy, err = 0; w_addr, f_tap, f_ic, oc_idx = 0; frame_cnt=0. Reset mid-frame abandons the frame; no done pulse.
- States: IDLE, CONV, DRAIN, LSTM_START, LSTM_WAIT, DONE.
- IDLE:
  - frame_ready=1.
  - On frame_valid, go to CONV next cycle with counters zeroed.
  - mac_valid rises on the cycle after acceptance.
- CONV:
  - mac_valid=1.
  - Indices advance only on a mac_valid&&mac_ready beat, ordered ic fastest, then tap, then oc.
  - All address and marker outputs hold stable while mac_ready=0.
  - mac_first = (tap==0 && ic==0).
  - mac_last = (tap==K-1 && ic==N_IN-1).
  - Outputs are registered from the counters; w_addr is maintained incrementally (+1 per beat), with no multiplier.
- CONV to DRAIN: on the beat with oc==N_OC-1 && mac_last. Exactly N_OC*K*N_IN beats per frame. mac_valid=0 from the next cycle.
- DRAIN: count MAC_LAT cycles, then go to LSTM_START.
- LSTM_START: lstm_start=1 for exactly one cycle, then LSTM_WAIT.
- LSTM_WAIT: remain until lstm_done=1, then DONE. No timeout.
- DONE: frame_done=1 for one cycle; frame_cnt increments; then IDLE. frame_ready=1 again the following cycle.
- Error detection: lstm_done sampled in any state other than LSTM_WAIT sets err (sticky until reset) and is otherwise ignored. This includes lstm_done coincident with lstm_start.
- frame_valid outside IDLE is ignored (frame_ready=0); there is no queuing.
- Counters wrap to 0 at the end of each frame; frame_cnt wraps silently.

Decomposition:
- Shared package nn_acc_pkg:
  - state enum seq_state_t;
  - default constants N_OC, K, N_IN;
  - localparam BEATS_PER_FRAME = N_OC*K*N_IN.
- One natural sub-module: nn_conv_addr_gen, holding the ic/tap/oc nested counters, incremental w_addr, and first/last flags, with an advance input and a wrap output. The FSM stays in the top level.

Test Plan:
All scenarios use N_OC=2, K=3, N_IN=4, MAC_LAT=2 (24 beats/frame).
- Happy path: frame_valid pulse with mac_ready=1 constant.
  - 24 mac_valid beats; w_addr 0..23.
  - mac_first at beats 0 and 12; mac_last at beats 11 and 23.
  - lstm_start exactly 3 cycles after beat 23.
  - lstm_done driven 5 cycles later, then frame_done 1 cycle after it; frame_cnt=1.
- Backpressure: mac_ready toggles 1,0,0,1,...
  - Indices and w_addr stable during every stall.
  - Still exactly 24 accepted beats; the w_addr sequence is identical to the happy path.
- Back-to-back frames: frame_valid held high.
  - Second frame accepted the cycle after frame_done; frame_ready=0 throughout busy.
  - frame_cnt=2; no beat is lost or duplicated.
- Stray done: lstm_done pulsed during CONV, then again coincident with lstm_start.
  - err=1 and stays 1; no state change.
  - A legitimate lstm_done in LSTM_WAIT still completes the frame.
- Reset mid-operation: assert reset_n=0 at beat 10 of CONV.
  - All outputs return to reset values immediately; no frame_done.
  - The next frame starts at w_addr=0; frame_cnt unchanged at 0.
- Counter wrap: preload frame_cnt=0xFFFF via force and complete one frame → frame_cnt=0x0000.
